// File: rtl/neuron_update_scheduler.sv
// Timestep sequencer: read v/u per neuron, hand off to the update unit, write the result back.
// Optional feature: define SPIKE_COUNT_EN to add the spike_count output.
module neuron_update_scheduler #(
    parameter int DATA_W      = 17,
    parameter int NUM_NEURONS = 2,
    parameter int TAG_W       = 1,
    parameter int TS_W        = 16
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic              start,
    input  logic              host_wr,
    input  logic [TAG_W-1:0]  host_tag,
    input  logic [DATA_W-1:0] host_v,
    input  logic [DATA_W-1:0] host_u,
    output logic              host_ack,
    output logic              busy,
    output logic              done,
    output logic [TS_W-1:0]   ts_count,
    output logic              err,
    output logic              sr_read,
    output logic              sr_write,
    output logic [TAG_W-1:0]  sr_tag,
    output logic [DATA_W-1:0] sr_v_new,
    output logic [DATA_W-1:0] sr_u_new,
    input  logic [DATA_W-1:0] sr_v,
    input  logic [DATA_W-1:0] sr_u,
    output logic              upd_valid,
    input  logic              upd_ready,
    output logic [DATA_W-1:0] upd_v,
    output logic [DATA_W-1:0] upd_u,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_v,
    input  logic [DATA_W-1:0] res_u,
`ifdef SPIKE_COUNT_EN
    output logic [TAG_W:0]    spike_count,
`endif
    input  logic              res_spike
);

    typedef enum logic [2:0] {
        S_IDLE, S_HOST, S_RD, S_CAP, S_ISSUE, S_WAIT, S_WB, S_FIN
    } state_t;

    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(NUM_NEURONS - 1);

    state_t           r_state;
    logic [TAG_W-1:0] r_tag;

`ifndef SPIKE_COUNT_EN
    logic w_unused_spike;
    assign w_unused_spike = res_spike;
`endif

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_state   <= S_IDLE;
            r_tag     <= '0;
            host_ack  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ts_count  <= '0;
            err       <= 1'b0;
            sr_read   <= 1'b0;
            sr_write  <= 1'b0;
            sr_tag    <= '0;
            sr_v_new  <= '0;
            sr_u_new  <= '0;
            upd_valid <= 1'b0;
            upd_v     <= '0;
            upd_u     <= '0;
`ifdef SPIKE_COUNT_EN
            spike_count <= '0;
`endif
        end else begin
            host_ack <= 1'b0;
            done     <= 1'b0;
            sr_read  <= 1'b0;
            sr_write <= 1'b0;

            if (res_valid && (r_state != S_WAIT)) begin
                err <= 1'b1;
            end

            // Outputs are registered, so each branch loads the strobes of the state it enters.
            case (r_state)
                S_IDLE: begin
                    if (host_wr) begin
                        r_state  <= S_HOST;
                        sr_write <= 1'b1;
                        sr_tag   <= host_tag;
                        sr_v_new <= host_v;
                        sr_u_new <= host_u;
                        host_ack <= 1'b1;
                    end else if (start) begin
                        r_state <= S_RD;
                        r_tag   <= '0;
                        busy    <= 1'b1;
                        sr_read <= 1'b1;
                        sr_tag  <= '0;
`ifdef SPIKE_COUNT_EN
                        spike_count <= '0;
`endif
                    end
                end
                S_HOST: begin
                    r_state <= S_IDLE;
                end
                S_RD: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    upd_v     <= sr_v;
                    upd_u     <= sr_u;
                    upd_valid <= 1'b1;
                    r_state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (upd_ready) begin
                        upd_valid <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        sr_write <= 1'b1;
                        sr_tag   <= r_tag;
                        sr_v_new <= res_v;
                        sr_u_new <= res_u;
                        r_state  <= S_WB;
`ifdef SPIKE_COUNT_EN
                        if (res_spike) begin
                            spike_count <= spike_count + 1'b1;
                        end
`endif
                    end
                end
                S_WB: begin
                    if (r_tag == LAST_TAG) begin
                        r_state  <= S_FIN;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        ts_count <= ts_count + 1'b1;
                    end else begin
                        r_tag   <= r_tag + 1'b1;
                        sr_read <= 1'b1;
                        sr_tag  <= r_tag + 1'b1;
                        r_state <= S_RD;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
